// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: BOOT/FETCH/DECODE/EXEC/MEM/WB/MULDIV/HALT with a shared wait counter.
// Outputs are combinational from state and IR fields; memory stalls hold state until mem_ready or watchdog expiry.
module mips_multicycle_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int MEM_TIMEOUT   = 15,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       negative,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write_en,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src,
  output logic       reg_dest,
  output logic       reg_write_enable,
  output logic       mem_or_reg,
  output logic       does_shift_amount_need,
  output logic       is_unsigned,
  output logic       link,
  output logic       muldiv_busy,
  output logic       illegal,
  output logic       halted,
  output logic       mem_error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_MULDIV = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_RALU, C_SHIFT, C_MULDIV, C_IMM, C_LW, C_SW,
    C_BR, C_J, C_JAL, C_JR, C_SYSCALL
  } cls_t;

  localparam logic [CNT_W-1:0] L_MD_LAST = CNT_W'(MULDIV_CYCLES - 1);
  // The watchdog fires on the last allowed waiting cycle, so exactly MEM_TIMEOUT cycles are spent waiting.
  localparam logic [CNT_W-1:0] L_WD_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit               L_WD_EN   = (MEM_TIMEOUT != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_halted;
  logic             r_mem_error;

  cls_t w_cls;
  logic w_taken;
  logic w_uns;
  logic w_opnd;
  logic w_wd_expire;

  always_comb begin
    w_cls = C_ILL;
    case (opcode)
      6'b000000: begin
        case (func)
          6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b000100, 6'b000110: w_cls = C_RALU;
          6'b000000, 6'b000010, 6'b000011:                        w_cls = C_SHIFT;
          6'b011000, 6'b011010:                                   w_cls = C_MULDIV;
          6'b001000:                                              w_cls = C_JR;
          6'b001100:                                              w_cls = C_SYSCALL;
          default:                                                w_cls = C_ILL;
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111: w_cls = C_IMM;
      6'b100011:                                              w_cls = C_LW;
      6'b101011:                                              w_cls = C_SW;
      6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001: w_cls = C_BR;
      6'b000010:                                              w_cls = C_J;
      6'b000011:                                              w_cls = C_JAL;
      default:                                                w_cls = C_ILL;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (opcode)
      6'b000100: w_taken = zero;
      6'b000101: w_taken = !zero;
      6'b000110: w_taken = zero || negative;
      6'b000111: w_taken = !zero && !negative;
      6'b000001: w_taken = !negative;
      default:   w_taken = 1'b0;
    endcase
  end

  assign w_uns       = (opcode == 6'b001001) || (opcode == 6'b001100) ||
                       (opcode == 6'b001101) || (opcode == 6'b001110);
  assign w_opnd      = (r_state == S_EXEC) || (r_state == S_MEM) ||
                       (r_state == S_WB)   || (r_state == S_MULDIV);
  assign w_wd_expire = L_WD_EN && (r_cnt == L_WD_LAST);

  always_comb begin
    mem_req                = 1'b0;
    mem_write_en           = 1'b0;
    ir_we                  = 1'b0;
    pc_we                  = 1'b0;
    pc_src                 = 2'd0;
    alu_src                = 1'b0;
    reg_dest               = 1'b0;
    reg_write_enable       = 1'b0;
    mem_or_reg             = 1'b0;
    does_shift_amount_need = 1'b0;
    is_unsigned            = 1'b0;
    link                   = 1'b0;
    muldiv_busy            = 1'b0;
    illegal                = 1'b0;
    // Operand selects persist past EXEC so the datapath holds its operands until writeback.
    if (w_opnd) begin
      reg_dest               = (w_cls == C_RALU) || (w_cls == C_SHIFT);
      does_shift_amount_need = (w_cls == C_SHIFT);
      alu_src                = (w_cls == C_IMM) || (w_cls == C_LW) || (w_cls == C_SW);
      is_unsigned            = w_uns;
    end
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_EXEC: begin
        case (w_cls)
          C_RALU, C_SHIFT, C_MULDIV, C_IMM, C_LW, C_SW: ;
          C_BR: begin
            pc_src = 2'd1;
            pc_we  = w_taken;
          end
          C_J: begin
            pc_we  = 1'b1;
            pc_src = 2'd2;
          end
          C_JAL: begin
            pc_we            = 1'b1;
            pc_src           = 2'd2;
            link             = 1'b1;
            reg_write_enable = 1'b1;
          end
          C_JR: begin
            pc_we  = 1'b1;
            pc_src = 2'd3;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_write_en = (w_cls == C_SW);
        mem_or_reg   = (w_cls == C_LW);
      end
      S_WB: begin
        reg_write_enable = 1'b1;
        mem_or_reg       = (w_cls == C_LW);
      end
      S_MULDIV: muldiv_busy = 1'b1;
      default: ;
    endcase
  end

  assign halted    = r_halted;
  assign mem_error = r_mem_error;
  assign state     = r_state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= S_BOOT;
      r_cnt       <= '0;
      r_halted    <= 1'b0;
      r_mem_error <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
          r_cnt   <= '0;
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_state <= S_DECODE;
            r_cnt   <= '0;
          end else if (w_wd_expire) begin
            r_state     <= S_HALT;
            r_cnt       <= '0;
            r_halted    <= 1'b1;
            r_mem_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          r_cnt <= '0;
          if (w_cls == C_SYSCALL) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt <= '0;
          case (w_cls)
            C_RALU, C_SHIFT, C_IMM: r_state <= S_WB;
            C_MULDIV:               r_state <= S_MULDIV;
            C_LW, C_SW:             r_state <= S_MEM;
            default:                r_state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_state <= (w_cls == C_SW) ? S_FETCH : S_WB;
            r_cnt   <= '0;
          end else if (w_wd_expire) begin
            r_state     <= S_HALT;
            r_cnt       <= '0;
            r_halted    <= 1'b1;
            r_mem_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_cnt   <= '0;
        end
        S_MULDIV: begin
          if (r_cnt == L_MD_LAST) begin
            r_state <= S_WB;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HALT: r_halted <= 1'b1;
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule
